spi_ram_slave_p: RTL and testbench
==================================

# spi_ram_slave_p

Parametrised SPI-slave-plus-RAM block, the next generation of the project's SPI/RAM wrapper. It deserialises MOSI command frames sampled on `clk`, executes address-load, write and read operations on an internal single-port memory, and serialises read data back on MISO. Data width and address width are generic, and an optional auto-increment mode supports burst access. It sits directly behind the chip-level SPI pins, and `clk` doubles as SCK.

## Interface
- `ADDR_W`, default 8: address width; memory depth = 2^ADDR_W; must satisfy ADDR_W <= DATA_W.
- `DATA_W`, default 8: memory word width and frame payload width.
- `AUTO_INC`, default 1: when 1, the write pointer increments after each write and the read pointer increments after each read.

- `clk` in 1: single clock, also serves as SPI SCK; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `SS_n` in 1: slave select, active low; high aborts or ends a frame.
- `MOSI` in 1: serial command/data in, MSB first.
- `MISO` out 1: serial read data out, MSB first, registered.
- `cmd_done` out 1: one-cycle pulse on a successfully executed command.

## Operation
- Frame = 2-bit opcode followed by DATA_W payload bits, 2+DATA_W bits total, MSB first.
- Opcode `00` sets the write pointer: `wr_ptr <= payload[ADDR_W-1:0]`; upper payload bits are ignored.
- Opcode `01` writes memory: `mem[wr_ptr] <= payload`, then `wr_ptr+1` if AUTO_INC=1.
- Opcode `10` sets the read pointer: `rd_ptr <= payload[ADDR_W-1:0]`.
- Opcode `11` reads memory: `mem[rd_ptr]` is shifted out on MISO, then `rd_ptr+1` if AUTO_INC=1. Its payload bits are don't-care.
- Pointer increments wrap modulo 2^ADDR_W (2^ADDR_W-1 -> 0).
- FSM states: IDLE, RX, EXEC, TX, WAIT.
  - IDLE: on SS_n=0, capture MOSI as frame bit 0 and go to RX; otherwise stay.
  - RX: capture one bit per edge; on the edge capturing the last bit, go to EXEC.
  - EXEC: perform the opcode action and pulse `cmd_done`. Opcode 11 goes to TX; all others go to WAIT.
  - TX: shift out DATA_W bits, then go to WAIT.
  - WAIT: ignore MOSI; on SS_n=1, go to IDLE.
- SS_n=1 on any edge in RX, EXEC or TX aborts the frame:
  - next state IDLE, MISO <= 0;
  - no memory write, pointer update or `cmd_done`.
- Memory contents are not affected by `rst`.
- Reset values: `MISO`=0, `cmd_done`=0, state IDLE, `wr_ptr`=0, `rd_ptr`=0, shift registers and bit counter 0.
- `rst` has priority over every other event, including mid-TX; MISO is 0 on the cycle after the reset edge.
- MISO changes only in EXEC (opcode 11) and TX; it is 0 in IDLE, RX and WAIT.

## Timing
- Let E0 be the rising edge on which IDLE samples SS_n=0.
- Frame bits are captured on E0..E(DATA_W+1).
- EXEC occurs on E(DATA_W+2). The memory write or pointer load commits on this edge, and `cmd_done`=1 for the following cycle.
- Opcode 11 output sequence:
  - after E(DATA_W+2+k), MISO = `mem[rd_ptr][DATA_W-1-k]`, for k = 0..DATA_W-1;
  - after E(2·DATA_W+2), MISO = 0 and the state is WAIT.
- For DATA_W=8: bits on E0..E9, EXEC on E10, MISO data valid after E10..E17, MISO=0 after E18.
- Memory read is synchronous on the EXEC edge; a write in the immediately preceding frame is visible to the read.
- Back-to-back frames: SS_n must be high for at least one edge between frames (WAIT->IDLE). The next frame starts on the following SS_n=0 edge.
- Maximum SS_n-low duration per frame is unbounded; WAIT holds until SS_n rises.

## Test plan
- Reset: assert `rst` for 2 cycles with SS_n=0 and MOSI toggling -> MISO=0 and `cmd_done`=0 on every cycle after the first reset edge; the first frame after reset starts in IDLE.
- Basic write/read (defaults): frames `00_0x05`, `01_0xA5`, `10_0x05`, `11_0x00` -> `cmd_done` pulses 4 times, and MISO after E10..E17 of the 4th frame = 1,0,1,0,0,1,0,1.
- Auto-increment wrap (AUTO_INC=1):
  - write pointer to 0xFF, write 0x11 then 0x22;
  - set read pointer to 0xFF, read twice;
  - -> reads return 0x11 then 0x22, mem[0x00]=0x22.
- Abort: raise SS_n at E5 of an `01_0x3C` frame, after a prior write of 0x77 to address 0x10 with `wr_ptr`=0x10 -> mem[0x10] stays 0x77, `wr_ptr` is unchanged, no `cmd_done`, MISO stays 0, and the next full frame executes normally.
- Reset mid-read: assert `rst` at E13 of an opcode-11 frame -> MISO=0 from the next cycle, state IDLE, `rd_ptr`=0, memory contents unchanged (verified by a subsequent read).
- Generic width (ADDR_W=4, DATA_W=12):
  - write 0xABC to address 0xF, then read it back;
  - -> frame is 14 bits, EXEC on E14, MISO shows 0xABC MSB-first after E14..E25, and 0 after E26.

Source files
------------

// File: rtl/spi_ram_slave_p_if.sv
// spi_ram_slave_p_if: chip-level SPI pins plus the command-done strobe
interface spi_ram_slave_p_if;
  logic SS_n;
  logic MOSI;
  logic MISO;
  logic cmd_done;
  modport master (output SS_n, MOSI, input MISO, cmd_done);
  modport slave (input SS_n, MOSI, output MISO, cmd_done);
endinterface

// File: rtl/spi_ram_slave_p.sv
// spi_ram_slave_p: SPI frame decoder driving a single-port RAM with optional burst auto-increment
module spi_ram_slave_p #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter bit AUTO_INC = 1'b1
) (
  input logic clk,
  input logic rst,
  spi_ram_slave_p_if.slave bus
);
  localparam int FW = DATA_W + 2;
  localparam int CW = $clog2(FW + 1);
  localparam logic [CW-1:0] RX_LAST = CW'(FW - 1);
  localparam logic [CW-1:0] TX_LAST = CW'(DATA_W - 1);
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(AUTO_INC);
  typedef enum logic [2:0] {IDLE, RX, EXEC, TX, WAIT} state_t;
  state_t state, state_n;
  logic [FW-1:0] rx_sh, rx_n;
  logic [DATA_W-1:0] tx_sh, tx_n, payload, rd_data;
  logic [CW-1:0] cnt, cnt_n;
  logic [ADDR_W-1:0] wr_ptr, wr_ptr_n, rd_ptr, rd_ptr_n;
  logic [1:0] op;
  logic miso, miso_n, done, done_n, we;
  logic [DATA_W-1:0] mem [2**ADDR_W];
  assign op = rx_sh[FW-1 -: 2];
  assign payload = rx_sh[DATA_W-1:0];
  assign rd_data = mem[rd_ptr];
  assign bus.MISO = miso;
  assign bus.cmd_done = done;
  always_comb begin
    state_n = state;
    rx_n = rx_sh;
    tx_n = tx_sh;
    cnt_n = cnt;
    wr_ptr_n = wr_ptr;
    rd_ptr_n = rd_ptr;
    miso_n = 1'b0;
    done_n = 1'b0;
    we = 1'b0;
    case (state)
      IDLE: if (!bus.SS_n) begin
        state_n = RX;
        rx_n = {rx_sh[FW-2:0], bus.MOSI};
        cnt_n = CW'(1);
      end
      RX: if (bus.SS_n) state_n = IDLE;
      else begin
        rx_n = {rx_sh[FW-2:0], bus.MOSI};
        cnt_n = cnt + 1'b1;
        state_n = cnt == RX_LAST ? EXEC : RX;
      end
      EXEC: if (bus.SS_n) state_n = IDLE;
      else begin
        done_n = 1'b1;
        cnt_n = '0;
        state_n = op == 2'b11 ? TX : WAIT;
        case (op)
          2'b00: wr_ptr_n = payload[ADDR_W-1:0];
          2'b01: begin
            we = 1'b1;
            wr_ptr_n = wr_ptr + STEP;
          end
          2'b10: rd_ptr_n = payload[ADDR_W-1:0];
          default: begin
            tx_n = rd_data;
            miso_n = rd_data[DATA_W-1];
            rd_ptr_n = rd_ptr + STEP;
          end
        endcase
      end
      TX: if (bus.SS_n) state_n = IDLE;
      else if (cnt == TX_LAST) state_n = WAIT;
      else begin
        tx_n = tx_sh << 1;
        miso_n = tx_n[DATA_W-1];
        cnt_n = cnt + 1'b1;
      end
      WAIT: state_n = bus.SS_n ? IDLE : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      rx_sh <= '0;
      tx_sh <= '0;
      cnt <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      miso <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      rx_sh <= rx_n;
      tx_sh <= tx_n;
      cnt <= cnt_n;
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      miso <= miso_n;
      done <= done_n;
    end
  // RAM has no reset; a reset edge still suppresses a pending write
  always_ff @(posedge clk)
    if (we && !rst) mem[wr_ptr] <= payload;
endmodule

// File: tb/tb_spi_ram_slave_p.sv
// tb_spi_ram_slave_p: directed and randomized frames on two widths against a behavioural memory model
module tb_spi_ram_slave_p;
  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  logic [15:0] mm [2][256];
  bit vld [2][256];
  int wp [2];
  int rp [2];
  always #5 clk = ~clk;
  spi_ram_slave_p_if b0 ();
  spi_ram_slave_p_if b1 ();
  spi_ram_slave_p dut0 (.clk(clk), .rst(rst), .bus(b0));
  spi_ram_slave_p #(.ADDR_W(4), .DATA_W(12), .AUTO_INC(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(b1));
  function automatic int dw(input int d);
    return d != 0 ? 12 : 8;
  endfunction
  function automatic int amask(input int d);
    return d != 0 ? 15 : 255;
  endfunction
  function automatic logic miso_of(input int d);
    return d != 0 ? b1.MISO : b0.MISO;
  endfunction
  function automatic logic done_of(input int d);
    return d != 0 ? b1.cmd_done : b0.cmd_done;
  endfunction
  task automatic step(input int d, input logic ss, input logic mosi);
    if (d == 0) begin
      b0.SS_n = ss;
      b0.MOSI = mosi;
    end else begin
      b1.SS_n = ss;
      b1.MOSI = mosi;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset;
    for (int d = 0; d < 2; d++) begin
      wp[d] = 0;
      rp[d] = 0;
    end
  endtask
  task automatic frame(input int d, input logic [1:0] op, input logic [15:0] pay, output logic [15:0] got);
    int w;
    int dmask;
    int extra;
    logic [17:0] f;
    logic [15:0] exp_rd;
    logic exp_bit;
    w = dw(d);
    dmask = (1 << w) - 1;
    f = (18'(op) << w) | 18'(pay & 16'(dmask));
    got = '0;
    exp_rd = '0;
    for (int i = 0; i < w + 2; i++) begin
      step(d, 1'b0, f[w + 1 - i]);
      vectors++;
      if (miso_of(d) !== 1'b0 || done_of(d) !== 1'b0) begin
        miscompares++;
        $display("FAIL rx d%0d bit%0d: miso=%b done=%b, need 0/0", d, i, miso_of(d), done_of(d));
      end
    end
    case (op)
      2'b00: wp[d] = int'(pay) & amask(d);
      2'b01: begin
        mm[d][wp[d]] = pay & 16'(dmask);
        vld[d][wp[d]] = 1'b1;
        wp[d] = (wp[d] + 1) & amask(d);
      end
      2'b10: rp[d] = int'(pay) & amask(d);
      default: begin
        exp_rd = mm[d][rp[d]];
        rp[d] = (rp[d] + 1) & amask(d);
      end
    endcase
    step(d, 1'b0, 1'($urandom));
    exp_bit = op == 2'b11 ? exp_rd[w-1] : 1'b0;
    vectors++;
    if (done_of(d) !== 1'b1 || miso_of(d) !== exp_bit) begin
      miscompares++;
      $display("FAIL exec d%0d op%0d: done=%b miso=%b, need 1/%b", d, op, done_of(d), miso_of(d), exp_bit);
    end
    got[w-1] = miso_of(d);
    if (op == 2'b11) begin
      for (int k = 1; k < w; k++) begin
        step(d, 1'b0, 1'($urandom));
        vectors++;
        if (done_of(d) !== 1'b0 || miso_of(d) !== exp_rd[w-1-k]) begin
          miscompares++;
          $display("FAIL tx d%0d k%0d: done=%b miso=%b, need 0/%b", d, k, done_of(d), miso_of(d), exp_rd[w-1-k]);
        end
        got[w-1-k] = miso_of(d);
      end
      step(d, 1'b0, 1'($urandom));
      vectors++;
      if (miso_of(d) !== 1'b0 || done_of(d) !== 1'b0) begin
        miscompares++;
        $display("FAIL tx_end d%0d: miso=%b done=%b, need 0/0", d, miso_of(d), done_of(d));
      end
    end
    extra = $urandom_range(2);
    for (int j = 0; j < extra; j++) begin
      step(d, 1'b0, 1'($urandom));
      vectors++;
      if (miso_of(d) !== 1'b0 || done_of(d) !== 1'b0) begin
        miscompares++;
        $display("FAIL wait d%0d: miso=%b done=%b, need 0/0", d, miso_of(d), done_of(d));
      end
    end
    step(d, 1'b1, 1'($urandom));
    vectors++;
    if (miso_of(d) !== 1'b0 || done_of(d) !== 1'b0) begin
      miscompares++;
      $display("FAIL release d%0d: miso=%b done=%b, need 0/0", d, miso_of(d), done_of(d));
    end
  endtask
  task automatic test_reset;
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      b0.SS_n = 1'b0;
      b1.SS_n = 1'b0;
      b0.MOSI = 1'(i);
      b1.MOSI = 1'(i + 1);
      @(posedge clk);
      #1;
      vectors++;
      if (b0.MISO !== 1'b0 || b0.cmd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset0 cyc%0d: miso=%b done=%b, need 0/0", i, b0.MISO, b0.cmd_done);
      end
      vectors++;
      if (b1.MISO !== 1'b0 || b1.cmd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL reset1 cyc%0d: miso=%b done=%b, need 0/0", i, b1.MISO, b1.cmd_done);
      end
    end
    rst = 1'b0;
    b1.SS_n = 1'b1;
  endtask
  task automatic test_basic;
    logic [15:0] g;
    frame(0, 2'b00, 16'h05, g);
    frame(0, 2'b01, 16'hA5, g);
    frame(0, 2'b10, 16'h05, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h00A5) begin
      miscompares++;
      $display("FAIL basic_read: got %h, need 00a5", g);
    end
  endtask
  task automatic test_wrap;
    logic [15:0] g;
    frame(0, 2'b00, 16'hFF, g);
    frame(0, 2'b01, 16'h11, g);
    frame(0, 2'b01, 16'h22, g);
    frame(0, 2'b10, 16'hFF, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h0011) begin
      miscompares++;
      $display("FAIL wrap_rd0: got %h, need 0011", g);
    end
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h0022) begin
      miscompares++;
      $display("FAIL wrap_rd1: got %h, need 0022", g);
    end
    frame(0, 2'b10, 16'h00, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h0022) begin
      miscompares++;
      $display("FAIL wrap_mem0: got %h, need 0022", g);
    end
  endtask
  task automatic test_abort;
    logic [15:0] g;
    logic [9:0] f;
    frame(0, 2'b00, 16'h10, g);
    frame(0, 2'b01, 16'h77, g);
    frame(0, 2'b00, 16'h10, g);
    f = {2'b01, 8'h3C};
    for (int i = 0; i < 9; i++) begin
      step(0, i >= 5, f[9 - i]);
      vectors++;
      if (b0.MISO !== 1'b0 || b0.cmd_done !== 1'b0) begin
        miscompares++;
        $display("FAIL abort e%0d: miso=%b done=%b, need 0/0", i, b0.MISO, b0.cmd_done);
      end
    end
    frame(0, 2'b10, 16'h10, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h0077) begin
      miscompares++;
      $display("FAIL abort_mem: got %h, need 0077", g);
    end
    frame(0, 2'b01, 16'h5A, g);
    frame(0, 2'b10, 16'h10, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h005A) begin
      miscompares++;
      $display("FAIL abort_wrptr: got %h, need 005a", g);
    end
  endtask
  task automatic test_reset_mid_read;
    logic [15:0] g;
    logic [9:0] f;
    logic [7:0] d;
    frame(0, 2'b10, 16'h10, g);
    d = mm[0][16'h10][7:0];
    f = {2'b11, 8'h00};
    for (int i = 0; i < 13; i++) begin
      step(0, 1'b0, f[9 - (i < 10 ? i : 0)]);
      if (i >= 10) begin
        vectors++;
        if (b0.MISO !== d[17 - i]) begin
          miscompares++;
          $display("FAIL midrd_tx e%0d: miso=%b, need %b", i, b0.MISO, d[17 - i]);
        end
      end
    end
    rst = 1'b1;
    step(0, 1'b0, 1'b1);
    model_reset();
    vectors++;
    if (b0.MISO !== 1'b0 || b0.cmd_done !== 1'b0) begin
      miscompares++;
      $display("FAIL midrd_rst: miso=%b done=%b, need 0/0", b0.MISO, b0.cmd_done);
    end
    rst = 1'b0;
    step(0, 1'b1, 1'b0);
    vectors++;
    if (b0.MISO !== 1'b0) begin
      miscompares++;
      $display("FAIL midrd_idle: miso=%b, need 0", b0.MISO);
    end
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h0022) begin
      miscompares++;
      $display("FAIL midrd_rdptr0: got %h, need 0022", g);
    end
    frame(0, 2'b10, 16'h10, g);
    frame(0, 2'b11, 16'h00, g);
    vectors++;
    if (g !== 16'h005A) begin
      miscompares++;
      $display("FAIL midrd_mem: got %h, need 005a", g);
    end
  endtask
  task automatic test_generic;
    logic [15:0] g;
    frame(1, 2'b00, 16'h000F, g);
    frame(1, 2'b01, 16'h0ABC, g);
    frame(1, 2'b10, 16'h000F, g);
    frame(1, 2'b11, 16'h0000, g);
    vectors++;
    if (g !== 16'h0ABC) begin
      miscompares++;
      $display("FAIL generic_read: got %h, need 0abc", g);
    end
  endtask
  task automatic test_random(input int d, input int n);
    logic [15:0] g;
    logic [1:0] op;
    logic [15:0] p;
    for (int i = 0; i < n; i++) begin
      op = 2'($urandom);
      p = 16'($urandom);
      if (op == 2'b11 && !vld[d][rp[d]]) op = 2'b01;
      frame(d, op, p, g);
    end
  endtask
  initial begin
    rst = 1'b1;
    b0.SS_n = 1'b0;
    b0.MOSI = 1'b0;
    b1.SS_n = 1'b0;
    b1.MOSI = 1'b0;
    test_reset();
    test_basic();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_generic();
    test_random(0, 150);
    test_random(1, 60);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
